// File: rtl/lane_rr_sched_pkg.sv
// Shared lane scheduler definitions: default lane count, FSM encoding, index width helper.
// Pure declarations; no logic, no latency.
package lane_rr_sched_pkg;

    localparam int LANE_MAX_DEF = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Index width that stays legal (non-zero) for a single-lane build.
    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lane_pend_cnt.sv
// Saturating per-lane pending counter; updates on the clock edge after inc/dec.
// No backpressure: an inc arriving at full scale without a dec is dropped and flagged on sat_drop.
module lane_pend_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         sat_drop
);

    assign sat_drop = inc && !dec && (cnt == {W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec && !sat_drop) begin
            cnt <= cnt + W'(1);
        end else if (dec && !inc) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/lane_rr_sched.sv
// Round-robin issue scheduler over active lanes; a request reaches out_valid one cycle after it is counted.
// out_lane holds while out_valid && !out_ready; back-to-back grants at one per cycle when out_ready is high.
module lane_rr_sched
    import lane_rr_sched_pkg::*;
#(
    parameter int                  LANE_MAX = LANE_MAX_DEF,
    parameter int                  SIZE     = LANE_MAX,
    parameter logic [LANE_MAX-1:0] MASK     = {LANE_MAX{1'b1}},
    parameter int                  CNT_W    = 3,
    localparam int                 LW       = lane_w(LANE_MAX)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANE_MAX-1:0]       req,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LW-1:0]             out_lane,
    output logic [LANE_MAX*CNT_W-1:0] pending,
    output logic                      overflow
);

    logic [LANE_MAX-1:0] elig;
    logic [LANE_MAX-1:0] dec;
    logic [LANE_MAX-1:0] drop;
    logic [LW-1:0]       ptr;
    logic [LW-1:0]       grant;
    logic                found;
    logic                load;
    state_t              state;
    state_t              state_nxt;

    // SIZE is tested before MASK so no MASK bit at or above SIZE is ever referenced.
    for (genvar g = 0; g < LANE_MAX; g++) begin : g_lane
        if (g < SIZE) begin : g_pop
            if (MASK[g]) begin : g_act
                logic [CNT_W-1:0] cnt;

                lane_pend_cnt #(.W(CNT_W)) u_cnt (
                    .clk      (clk),
                    .rst_n    (rst_n),
                    .inc      (req[g]),
                    .dec      (dec[g]),
                    .cnt      (cnt),
                    .sat_drop (drop[g])
                );

                assign elig[g]                   = |cnt;
                assign pending[g*CNT_W +: CNT_W] = cnt;
            end else begin : g_masked
                logic unused_in;
                assign unused_in                 = req[g] | dec[g];
                assign elig[g]                   = 1'b0;
                assign drop[g]                   = 1'b0;
                assign pending[g*CNT_W +: CNT_W] = '0;
            end
        end else begin : g_absent
            logic unused_in;
            assign unused_in                 = req[g] | dec[g];
            assign elig[g]                   = 1'b0;
            assign drop[g]                   = 1'b0;
            assign pending[g*CNT_W +: CNT_W] = '0;
        end
    end

    // Search starts just past the last grant and wraps, so every eligible lane is reached within LANE_MAX steps.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        grant = ptr;
        for (int k = 1; k <= LANE_MAX; k++) begin
            idx = (int'(ptr) + k) % LANE_MAX;
            if (!found && elig[LW'(idx)]) begin
                found = 1'b1;
                grant = LW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        dec       = '0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    load      = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (found) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (load) begin
            dec[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= LW'(LANE_MAX - 1);
            out_lane <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            overflow <= overflow | (|drop);
            if (load) begin
                ptr      <= grant;
                out_lane <= grant;
            end
        end
    end

    assign out_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_lane_rr_sched.sv
// Drives three scheduler builds (full, masked hole, SIZE=2) with shared stimulus and scores them against a reference model.
module tb_lane_rr_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0;
    logic       out_ready = 1'b0;

    logic [2:0]  dv;
    logic [2:0]  dov;
    logic [1:0]  dl [3];
    logic [11:0] dp [3];

    int n_checks = 0;
    int n_pass   = 0;
    bit checking = 1'b0;

    // reference model state per DUT
    int m_cnt  [3][4];
    int m_ptr  [3];
    bit m_busy [3];
    int m_lane [3];
    bit m_ovf  [3];
    int exp_q  [3][$];

    always #5 clk = ~clk;

    lane_rr_sched #(.LANE_MAX(4), .SIZE(4), .MASK(4'b1111), .CNT_W(3)) u_full (
        .clk(clk), .rst_n(rst_n), .req(req), .out_valid(dv[0]), .out_ready(out_ready),
        .out_lane(dl[0]), .pending(dp[0]), .overflow(dov[0])
    );

    lane_rr_sched #(.LANE_MAX(4), .SIZE(4), .MASK(4'b1011), .CNT_W(3)) u_hole (
        .clk(clk), .rst_n(rst_n), .req(req), .out_valid(dv[1]), .out_ready(out_ready),
        .out_lane(dl[1]), .pending(dp[1]), .overflow(dov[1])
    );

    lane_rr_sched #(.LANE_MAX(4), .SIZE(2), .MASK(4'b1111), .CNT_W(3)) u_size2 (
        .clk(clk), .rst_n(rst_n), .req(req), .out_valid(dv[2]), .out_ready(out_ready),
        .out_lane(dl[2]), .pending(dp[2]), .overflow(dov[2])
    );

    function automatic bit active(input int d, input int l);
        logic [3:0] a;
        case (d)
            0:       a = 4'b1111;
            1:       a = 4'b1011;
            default: a = 4'b0011;
        endcase
        return a[l];
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int l = 0; l < 4; l++) m_cnt[d][l] = 0;
            m_ptr[d]  = 3;
            m_busy[d] = 1'b0;
            m_lane[d] = 0;
            m_ovf[d]  = 1'b0;
            exp_q[d].delete();
        end
    endtask

    // One clock edge of the scheduling rules, applied to each build.
    task automatic model_edge(input logic [3:0] r, input logic rdy);
        for (int d = 0; d < 3; d++) begin
            int g;
            int nv;
            bit hs;
            g  = -1;
            hs = m_busy[d] && rdy;
            if (!m_busy[d] || hs) begin
                for (int k = 1; k <= 4; k++) begin
                    int l;
                    l = (m_ptr[d] + k) % 4;
                    if (g < 0 && active(d, l) && m_cnt[d][l] > 0) g = l;
                end
            end
            if (g >= 0) begin
                m_ptr[d]  = g;
                m_lane[d] = g;
                exp_q[d].push_back(g);
            end
            m_busy[d] = (g >= 0) ? 1'b1 : (m_busy[d] && !hs);
            for (int l = 0; l < 4; l++) begin
                if (active(d, l)) begin
                    nv = m_cnt[d][l] + int'(r[l]) - ((g == l) ? 1 : 0);
                    if (nv > 7) begin
                        nv       = 7;
                        m_ovf[d] = 1'b1;
                    end
                    m_cnt[d][l] = nv;
                end
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic rdy);
        req       = r;
        out_ready = rdy;
        @(posedge clk);
        model_edge(r, rdy);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_valid"}, int'(dv[d]), 0);
            chk({tag, "_lane"}, int'(dl[d]), 0);
            chk({tag, "_pending"}, int'(dp[d]), 0);
            chk({tag, "_overflow"}, int'(dov[d]), 0);
        end
    endtask

    // Monitor: state comparison every cycle, grant scoreboard on each handshake.
    always @(negedge clk) begin
        if (checking) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("valid_d%0d", d), int'(dv[d]), int'(m_busy[d]));
                chk($sformatf("overflow_d%0d", d), int'(dov[d]), int'(m_ovf[d]));
                for (int l = 0; l < 4; l++)
                    chk($sformatf("pending_d%0d_l%0d", d, l), int'(dp[d][l*3 +: 3]), m_cnt[d][l]);
                if (rst_n && dv[d] && out_ready) begin
                    if (exp_q[d].size() == 0) begin
                        chk($sformatf("unexpected_grant_d%0d", d), int'(dl[d]), -1);
                    end else begin
                        chk($sformatf("grant_d%0d", d), int'(dl[d]), exp_q[d].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0] r;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n    = 1'b1;
        checking = 1'b1;

        // inactive-lane suppression and masked hole, two rounds for wrap-around
        repeat (2) begin
            step(4'b1111, 1'b1);
            repeat (6) step(4'b0000, 1'b1);
        end

        // backpressure on lane 1
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        repeat (5) begin
            step(4'b0000, 1'b0);
            chk("bp_lane", int'(dl[0]), 1);
        end
        repeat (4) step(4'b0000, 1'b1);

        // saturation, then simultaneous inc/dec at full scale
        repeat (9) step(4'b0001, 1'b0);
        chk("sat_count", int'(dp[0][2:0]), 7);
        chk("sat_overflow", int'(dov[0]), 1);
        step(4'b0001, 1'b1);
        chk("sat_incdec", int'(dp[0][2:0]), 7);
        repeat (12) step(4'b0000, 1'b1);

        // reset mid-operation while lane 0 is held with 3 pending
        repeat (4) step(4'b0001, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("async_rst");
        #1;
        rst_n = 1'b1;
        step(4'b1000, 1'b1);
        chk("post_rst_valid_early", int'(dv[0]), 0);
        step(4'b0000, 1'b1);
        chk("post_rst_valid", int'(dv[0]), 1);
        chk("post_rst_lane", int'(dl[0]), 3);
        repeat (4) step(4'b0000, 1'b1);

        // fairness under continuous requests
        repeat (12) step(4'b1111, 1'b1);
        repeat (40) step(4'b0000, 1'b1);

        // randomized traffic
        repeat (400) begin
            for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 9) < 3);
            step(r, ($urandom_range(0, 3) != 0));
        end
        repeat (40) step(4'b0000, 1'b1);

        checking = 1'b0;
        for (int d = 0; d < 3; d++)
            chk($sformatf("drained_d%0d", d), exp_q[d].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
